// File: rtl/sum_secuencial32b.sv
// Multi-byte adder built around a single 8-bit slice, reused once per byte
// from the least significant byte upward. One result every N_BYTES+2 cycles.
module sum_secuencial32b #(
  parameter int N_BYTES = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Start,
  input  logic [8*N_BYTES-1:0]   i_bit1,
  input  logic [8*N_BYTES-1:0]   i_bit2,
  input  logic                   i_Carry,
  output logic [8*N_BYTES-1:0]   o_Suma,
  output logic                   o_Carry,
  output logic                   o_Busy,
  output logic                   o_Done
);

  localparam int W     = 8 * N_BYTES;
  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             carry_r;
  logic [IDX_W-1:0] idx;

  logic [7:0]       a_byte;
  logic [7:0]       b_byte;
  logic [7:0]       s_byte;
  logic             s_co;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The one shared slice: byte idx of the latched operands plus the running carry.
  assign a_byte = a_r[{idx, 3'b000} +: 8];
  assign b_byte = b_r[{idx, 3'b000} +: 8];
  assign {s_co, s_byte} = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_r};

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      o_Suma  <= '0;
      o_Carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Start) begin
            a_r     <= i_bit1;
            b_r     <= i_bit2;
            carry_r <= i_Carry;
            idx     <= '0;
            o_Suma  <= '0;
            o_Carry <= 1'b0;
          end
        end
        RUN: begin
          o_Suma[{idx, 3'b000} +: 8] <= s_byte;
          carry_r                    <= s_co;
          // Wrap the index to 0 on the last byte so it never points past the operand.
          if (idx == LAST) begin
            o_Carry <= s_co;
            idx     <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Busy = (state != IDLE);
  assign o_Done = (state == DONE);

endmodule

// File: tb/tb_sum_secuencial32b.sv
// Scoreboard bench for sum_secuencial32b (N_BYTES=4): stimulus pushes expected
// {carry,sum} into a queue, a negedge monitor pops and compares on every o_Done.
module tb_sum_secuencial32b;

  localparam int N_BYTES = 4;
  localparam int W       = 8 * N_BYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] suma;
  logic         carry;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [W:0] exp_q[$];

  sum_secuencial32b #(.N_BYTES(N_BYTES)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_Start (start),
    .i_bit1  (a),
    .i_bit2  (b),
    .i_Carry (cin),
    .o_Suma  (suma),
    .o_Carry (carry),
    .o_Busy  (busy),
    .o_Done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Monitor: every o_Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result_sum", 64'(suma), 64'(e[W-1:0]));
        check("result_carry", 64'(carry), 64'(e[W]));
      end
    end
  end

  // One operation issued in IDLE; verifies latency and busy window, result goes to the monitor.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int cyc;
    @(negedge clk);
    check("busy_idle_before", 64'(busy), 64'(0));
    a = x; b = y; cin = c; start = 1'b1;
    exp_q.push_back(model(x, y, c));
    @(negedge clk);
    start = 1'b0;
    a = ~x; b = ~y; cin = ~c;
    check("busy_after_accept", 64'(busy), 64'(1));
    check("carry_cleared_in_run", 64'(carry), 64'(0));
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 64'(cyc), 64'(N_BYTES));
    check("busy_in_done", 64'(busy), 64'(1));
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int d0;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset, with start asserted to show reset priority.
    @(negedge clk); start = 1'b1; a = '1; b = '1;
    repeat (2) @(negedge clk);
    check("rst_suma", 64'(suma), 64'(0));
    check("rst_carry", 64'(carry), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    start = 1'b0;
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    check("vec1_sum_hold", 64'(suma), 64'h0000_0100);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    check("vec2_sum_hold", 64'(suma), 64'h0000_0000);
    check("vec2_carry_hold", 64'(carry), 64'(1));
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("vec3_sum_hold", 64'(suma), 64'hFFFF_FFFF);
    run_op(32'd20, 32'd30, 1'b0);
    check("vec4_sum_hold", 64'(suma), 64'd50);
    check("vec4_carry_hold", 64'(carry), 64'(0));
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    check("vec5_carry_hold", 64'(carry), 64'(1));

    // Start held high, operands changing every cycle: accepts at j = 0, 6, 12, 18.
    d0 = n_done;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      x = 32'h8000_0000 + 32'(j) * 32'h1234_5679;
      y = 32'hFFFF_0000 - 32'(j) * 32'h0101_0101;
      c = j[0];
      a = x; b = y; cin = c; start = 1'b1;
      if (j % 6 == 0) exp_q.push_back(model(x, y, c));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("held_start_done_count", 64'(n_done - d0), 64'(4));

    // Reset two edges into RUN aborts with no done pulse.
    d0 = n_done;
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_suma", 64'(suma), 64'(0));
    check("abort_carry", 64'(carry), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", 64'(n_done - d0), 64'(0));
    run_op(32'd250, 32'd10, 1'b0);
    check("restart_sum_hold", 64'(suma), 64'd260);

    // Random operands against the reference model.
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_secuencial32b.md
SUM_SECUENCIAL32B -- requirements
Module: sum_secuencial32b

Interface
- REQ-001: Parameter N_BYTES, default 4: operand width in bytes; legal range 2..8.
- REQ-002: i_Clk  input  1  single clock for the block; all state changes occur on the rising edge.
- REQ-003: i_Rst_n  input  1  reset; synchronous, active-low.
- REQ-004: i_Start  input  1  request to start an addition; sampled only in IDLE.
- REQ-005: i_bit1  input  8*N_BYTES  operand A.
- REQ-006: i_bit2  input  8*N_BYTES  operand B.
- REQ-007: i_Carry  input  1  carry-in, added at byte 0.
- REQ-008: o_Suma  output  8*N_BYTES  registered sum, A+B+Cin mod 2^(8*N_BYTES).
- REQ-009: o_Carry  output  1  registered carry-out of the most significant byte.
- REQ-010: o_Busy  output  1  high in RUN and DONE.
- REQ-011: o_Done  output  1  one-cycle pulse; result is valid.

Function
- REQ-012: The block SHALL contain exactly one 8-bit combinational adder slice: a[7:0] + b[7:0] + c -> s[7:0], co. It SHALL time-share that slice across all bytes, least significant byte first.
- REQ-013: The FSM SHALL have three states: IDLE, RUN and DONE. Its encoding is free.
- REQ-014: IDLE: when i_Start=1 at an edge, the block SHALL perform all of the following, then go to RUN:
  - latch i_bit1, i_bit2 and i_Carry into internal registers;
  - set the byte index to 0 and the carry register to i_Carry;
  - clear o_Suma and o_Carry to 0.
- REQ-015: IDLE with i_Start=0: the state SHALL hold, and o_Suma/o_Carry SHALL retain the last result.
- REQ-016: RUN, at each edge for byte index k:
  - write byte k of o_Suma with the slice sum of latched A byte k, latched B byte k and the carry register;
  - load the carry register with the slice carry-out;
  - increment k.
- REQ-017: RUN SHALL last exactly N_BYTES edges. On the edge that processes byte N_BYTES-1, the block SHALL load o_Carry with the slice carry-out and go to DONE.
- REQ-018: DONE SHALL hold o_Done=1 for exactly one cycle; on the next edge the FSM SHALL return to IDLE unconditionally.
- REQ-019: Latency: with i_Start sampled at edge t, o_Done SHALL be high during the cycle between edges t+N_BYTES and t+N_BYTES+1.
- REQ-020: Issue rate: a new i_Start SHALL be accepted no earlier than edge t+N_BYTES+2, i.e. one operation every N_BYTES+2 cycles.
- REQ-021: i_Start in RUN or DONE SHALL be ignored and not queued.
- REQ-022: Changes to i_bit1, i_bit2 or i_Carry after acceptance SHALL NOT affect the operation in progress.
- REQ-023: During RUN, o_Suma bytes above the current index SHALL read 0; the value is meaningful only when o_Done=1 or in IDLE afterwards.
- REQ-024: Wrap-around: the sum SHALL be taken modulo 2^(8*N_BYTES), with the overflow reported only on o_Carry; no signed overflow flag.
- REQ-025: The byte index SHALL be ceil(log2(N_BYTES)) bits wide or wider, and SHALL never address beyond byte N_BYTES-1.

Reset
- REQ-026: i_Rst_n=0 at an edge SHALL force all of the following, with priority over i_Start and over any state:
  - state IDLE;
  - o_Suma=0, o_Carry=0, o_Busy=0, o_Done=0;
  - byte index, carry register and operand registers to 0.
- REQ-027: Reset asserted mid-RUN SHALL abort the operation with no o_Done pulse. The first i_Start after reset release SHALL be accepted normally.
- REQ-028: Outputs SHALL NOT change asynchronously with i_Rst_n.

Verification (N_BYTES=4)
- REQ-029: A=0x000000FF, B=0x00000001, Cin=0, start at edge t -> o_Done high after edge t+4, o_Suma=0x00000100, o_Carry=0; o_Busy high from t+1 to t+5.
- REQ-030: A=0xFFFFFFFF, B=0x00000000, Cin=1 -> o_Suma=0x00000000, o_Carry=1 (carry ripples through all 4 bytes).
- REQ-031: A=0xFFFFFFFF, B=0xFFFFFFFF, Cin=1 -> o_Suma=0xFFFFFFFF, o_Carry=1. Then A=20, B=30, Cin=0 started at the earliest legal edge -> o_Suma=50, o_Carry=0.
- REQ-032: i_Start held high continuously, with operands changed every cycle -> one o_Done every 6 cycles. Each result SHALL match the operands present at its own accept edge.
- REQ-033: Reset pulled low 2 edges into RUN -> the next cycle shows all outputs 0 and no o_Done. A restart with A=250, B=10, Cin=0 -> o_Suma=260, o_Carry=0.
- REQ-034: Randomized check: 1000 random A/B/Cin compared against a reference model of {o_Carry,o_Suma} = A+B+Cin, with zero mismatches.
